// File: rtl/hs_pipe_driver.sv
// Clocked controller for a 4-phase lr/la/rr/ra pipeline. It issues a programmed number of
// tokens on the left port and retires them on the right port, with timeout and protocol checking.
module hs_pipe_driver #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned COUNT_W      = 8,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned TIMEOUT      = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [COUNT_W-1:0] num_instr_i,
    output logic               lr_o,
    input  logic               la_i,
    input  logic               rr_i,
    output logic               ra_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [COUNT_W-1:0] issued_o,
    output logic [COUNT_W-1:0] retired_o
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_ERR} top_e;
    typedef enum logic [1:0] {I_IDLE, I_REQ, I_REL} iss_e;
    typedef enum logic       {R_WAIT, R_ACK}        ret_e;

    top_e               top_q;
    iss_e               iss_q;
    ret_e               ret_q;
    logic [SYNC_STAGES-1:0] la_sync_q, rr_sync_q;
    logic               la_prev_q, rr_prev_q;
    logic               lr_q, ra_q, busy_q, done_q, err_q;
    logic [COUNT_W-1:0] n_q, issued_q, retired_q;
    logic [TO_W-1:0]    idle_cnt_q;

    logic               la_s, rr_s;
    logic               la_rise, rr_rise, any_edge;
    logic               issue_fire, retire_fire;
    logic [COUNT_W-1:0] issued_d, retired_d, inflight_d;
    logic               viol, timeout_hit, run_done, can_issue;

    // Input synchronizers; only the last stage is visible to the control logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            la_sync_q <= '0;
            rr_sync_q <= '0;
            la_prev_q <= 1'b0;
            rr_prev_q <= 1'b0;
        end else begin
            la_sync_q <= {la_sync_q[SYNC_STAGES-2:0], la_i};
            rr_sync_q <= {rr_sync_q[SYNC_STAGES-2:0], rr_i};
            la_prev_q <= la_sync_q[SYNC_STAGES-1];
            rr_prev_q <= rr_sync_q[SYNC_STAGES-1];
        end
    end

    assign la_s = la_sync_q[SYNC_STAGES-1];
    assign rr_s = rr_sync_q[SYNC_STAGES-1];

    // Per-cycle events; in-flight count sees this cycle's issue and retire together.
    always_comb begin
        la_rise     = la_s & ~la_prev_q;
        rr_rise     = rr_s & ~rr_prev_q;
        any_edge    = (la_s ^ la_prev_q) | (rr_s ^ rr_prev_q);
        issue_fire  = (top_q == T_RUN) && (iss_q == I_REQ) && la_s;
        retire_fire = (top_q == T_RUN) && (ret_q == R_WAIT) && rr_s;
        issued_d    = issued_q + COUNT_W'(issue_fire);
        retired_d   = retired_q + COUNT_W'(retire_fire);
        inflight_d  = issued_d - retired_d;
        viol        = (la_rise && !lr_q)
                   || (rr_rise && (issued_d == retired_q))
                   || (rr_rise && (retired_q == n_q));
        timeout_hit = !any_edge && (idle_cnt_q >= TO_W'(TIMEOUT));
        run_done    = (retired_q == n_q) && (iss_q == I_IDLE) && !lr_q && !la_s && !ra_q;
        can_issue   = (issued_q < n_q) && (inflight_d < COUNT_W'(MAX_INFLIGHT));
    end

    // Top, issue and retire FSMs with their registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q      <= T_IDLE;
            iss_q      <= I_IDLE;
            ret_q      <= R_WAIT;
            lr_q       <= 1'b0;
            ra_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            n_q        <= '0;
            issued_q   <= '0;
            retired_q  <= '0;
            idle_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (top_q)
                T_IDLE, T_ERR: begin
                    if (start_i) begin
                        top_q      <= T_RUN;
                        n_q        <= num_instr_i;
                        issued_q   <= '0;
                        retired_q  <= '0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        idle_cnt_q <= '0;
                    end
                end
                T_RUN: begin
                    if (viol || timeout_hit) begin
                        top_q  <= T_ERR;
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        lr_q   <= 1'b0;
                        ra_q   <= 1'b0;
                        iss_q  <= I_IDLE;
                        ret_q  <= R_WAIT;
                    end else if (run_done) begin
                        top_q  <= T_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        idle_cnt_q <= any_edge ? '0 : idle_cnt_q + TO_W'(1);
                        issued_q   <= issued_d;
                        retired_q  <= retired_d;
                        case (iss_q)
                            I_IDLE: if (can_issue) begin
                                lr_q  <= 1'b1;
                                iss_q <= I_REQ;
                            end
                            I_REQ: if (la_s) begin
                                lr_q  <= 1'b0;
                                iss_q <= I_REL;
                            end
                            I_REL: if (!la_s) iss_q <= I_IDLE;
                            default: iss_q <= I_IDLE;
                        endcase
                        case (ret_q)
                            R_WAIT: if (rr_s) begin
                                ra_q  <= 1'b1;
                                ret_q <= R_ACK;
                            end
                            R_ACK: if (!rr_s) begin
                                ra_q  <= 1'b0;
                                ret_q <= R_WAIT;
                            end
                            default: ret_q <= R_WAIT;
                        endcase
                    end
                end
                default: top_q <= T_IDLE;
            endcase
        end
    end

    assign lr_o      = lr_q;
    assign ra_o      = ra_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign issued_o  = issued_q;
    assign retired_o = retired_q;

endmodule
